// File: rtl/seg7_scan_decoder.sv
// Decoder for a scanned, active-low 7-segment display: it debounces the digit samples,
// assembles units/tens/hundreds frames and checks each new value against a 24 or 150 wrap sequence.
module seg7_scan_decoder #(
  parameter int unsigned STABLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [2:0]  dig_sel,
  input  logic        mod_sel,
  input  logic        clr,
  output logic [11:0] bcd_val,
  output logic [9:0]  bin_val,
  output logic        val_valid,
  output logic        seg_err,
  output logic        seq_err,
  output logic        range_err
);

  localparam logic [3:0] STAB = 4'(STABLE);

  // Sample stability tracking
  logic [9:0]  r_prev_in;
  logic [3:0]  r_stab_cnt;
  logic [9:0]  w_in;
  logic        w_onehot;
  logic        w_changed;
  logic [3:0]  w_cnt_next;
  logic        w_accept;

  // Frame assembly
  logic [3:0]  r_dig_u, r_dig_t, r_dig_h;
  logic [2:0]  r_cap;
  logic        r_bad;
  logic [3:0]  w_dig_u, w_dig_t, w_dig_h;
  logic [2:0]  w_cap;
  logic        w_bad;
  logic        w_frame_done;
  logic [3:0]  w_digit;
  logic        w_illegal;

  // Completed frame waiting for evaluation
  logic        r_pend;
  logic [11:0] r_frame;
  logic        r_frame_bad;

  // Value / sequence stage
  logic [11:0] r_bcd;
  logic [9:0]  r_bin;
  logic        r_valid;
  logic        r_seg_err, r_seq_err, r_range_err;
  logic        r_has_prev;
  logic        r_mod_q;
  logic        w_mod_chg;
  logic [9:0]  w_frame_bin;
  logic [9:0]  w_limit;
  logic        w_update;
  logic        w_seq_ok;

  assign w_in      = {seg, dig_sel};
  assign w_onehot  = (dig_sel == 3'b001) || (dig_sel == 3'b010) || (dig_sel == 3'b100);
  assign w_changed = (w_in != r_prev_in);

  always_comb begin
    w_cnt_next = r_stab_cnt;
    if (!w_onehot)
      w_cnt_next = '0;
    else if (w_changed)
      w_cnt_next = 4'd1;
    else if (r_stab_cnt < STAB)
      w_cnt_next = r_stab_cnt + 4'd1;
  end

  // Fires once per run: either on the cycle the count first reaches STABLE, or
  // (STABLE=1) on the first cycle of a new run even if the counter already sat at 1.
  assign w_accept = w_onehot && (w_cnt_next == STAB) && (w_changed || (r_stab_cnt != STAB));

  always_comb begin
    w_digit   = 4'hF;
    w_illegal = 1'b0;
    case (seg)
      7'h40: w_digit = 4'd0;
      7'h79: w_digit = 4'd1;
      7'h24: w_digit = 4'd2;
      7'h30: w_digit = 4'd3;
      7'h19: w_digit = 4'd4;
      7'h12: w_digit = 4'd5;
      7'h02: w_digit = 4'd6;
      7'h78: w_digit = 4'd7;
      7'h00: w_digit = 4'd8;
      7'h10: w_digit = 4'd9;
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_dig_u = r_dig_u;
    w_dig_t = r_dig_t;
    w_dig_h = r_dig_h;
    w_cap   = r_cap;
    w_bad   = r_bad;
    if (w_accept) begin
      if (dig_sel[0]) w_dig_u = w_digit;
      if (dig_sel[1]) w_dig_t = w_digit;
      if (dig_sel[2]) w_dig_h = w_digit;
      w_cap = r_cap | dig_sel;
      if (w_illegal) w_bad = 1'b1;
    end
  end

  assign w_frame_done = &w_cap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_in  <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_prev_in  <= w_in;
      r_stab_cnt <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dig_u     <= '0;
      r_dig_t     <= '0;
      r_dig_h     <= '0;
      r_cap       <= '0;
      r_bad       <= 1'b0;
      r_pend      <= 1'b0;
      r_frame     <= '0;
      r_frame_bad <= 1'b0;
    end else begin
      r_dig_u <= w_dig_u;
      r_dig_t <= w_dig_t;
      r_dig_h <= w_dig_h;
      if (clr) begin
        r_cap  <= '0;
        r_bad  <= 1'b0;
        r_pend <= 1'b0;
      end else if (w_frame_done) begin
        r_cap       <= '0;
        r_bad       <= 1'b0;
        r_pend      <= 1'b1;
        r_frame     <= {w_dig_h, w_dig_t, w_dig_u};
        r_frame_bad <= w_bad;
      end else begin
        r_cap  <= w_cap;
        r_bad  <= w_bad;
        r_pend <= 1'b0;
      end
    end
  end

  assign w_frame_bin = (10'(r_frame[11:8]) * 10'd100)
                     + (10'(r_frame[7:4])  * 10'd10)
                     +  10'(r_frame[3:0]);
  assign w_limit   = mod_sel ? 10'd149 : 10'd23;
  assign w_mod_chg = (mod_sel != r_mod_q);
  assign w_update  = r_pend && !r_frame_bad && (r_frame != r_bcd);
  assign w_seq_ok  = (w_frame_bin == r_bin + 10'd1) ||
                     ((w_frame_bin == '0) && (r_bin == w_limit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd       <= '0;
      r_bin       <= '0;
      r_valid     <= 1'b0;
      r_seg_err   <= 1'b0;
      r_seq_err   <= 1'b0;
      r_range_err <= 1'b0;
      r_has_prev  <= 1'b0;
      r_mod_q     <= 1'b0;
    end else begin
      r_mod_q <= mod_sel;
      r_valid <= w_update;
      if (w_update) begin
        r_bcd <= r_frame;
        r_bin <= w_frame_bin;
      end
      // A mod_sel change coinciding with an update makes that value the new sequence start.
      if (clr) begin
        r_seg_err   <= 1'b0;
        r_seq_err   <= 1'b0;
        r_range_err <= 1'b0;
        r_has_prev  <= 1'b0;
      end else begin
        if (w_accept && w_illegal)
          r_seg_err <= 1'b1;
        if (w_update && (w_frame_bin > w_limit))
          r_range_err <= 1'b1;
        if (w_update && r_has_prev && !w_mod_chg && !w_seq_ok)
          r_seq_err <= 1'b1;
        if (w_update)
          r_has_prev <= 1'b1;
        else if (w_mod_chg)
          r_has_prev <= 1'b0;
      end
    end
  end

  assign bcd_val   = r_bcd;
  assign bin_val   = r_bin;
  assign val_valid = r_valid;
  assign seg_err   = r_seg_err;
  assign seq_err   = r_seq_err;
  assign range_err = r_range_err;

endmodule
